mult_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one sequential multiplier between NREQ requesters.

---
 rtl/mult_rr_scheduler_if.sv | 29 ++
 rtl/mult_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_mult_rr_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_scheduler_if.sv
// rtl/mult_rr_scheduler_if.sv - client and multiplier signal bundle for mult_rr_scheduler
interface mult_rr_scheduler_if #(
    parameter int N    = 4,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] op_a;
    logic [NREQ*N-1:0] op_b;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic [2*N-1:0]    res;
    logic              busy;
    logic [N-1:0]      m_a;
    logic [N-1:0]      m_b;
    logic              m_data_ready;
    logic              m_result_ready;
    logic [2*N-1:0]    m_result;

    modport master (
        input  req, op_a, op_b, m_result_ready, m_result,
        output grant, done, err, res, busy, m_a, m_b, m_data_ready
    );

    modport slave (
        output req, op_a, op_b, m_result_ready, m_result,
        input  grant, done, err, res, busy, m_a, m_b, m_data_ready
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin sharing of one sequential multiplier among NREQ clients
module mult_rr_scheduler #(
    parameter int N       = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_rr_scheduler_if.master  bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   rr_last;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic [CW-1:0]   cnt;
    logic            rdy_q;
    logic            accept;
    logic            timeout;
    logic            found;
    int              idx;
    logic [NREQ-1:0] grant_d;
    logic [NREQ-1:0] done_d;
    logic [NREQ-1:0] err_d;
    logic            mdr_d;
    logic            busy_d;

    // Only a fresh low-to-high edge counts; a level left high from before START is stale.
    assign accept  = bus.m_result_ready && !rdy_q;
    assign timeout = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_last) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (|bus.req) state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT:  if (accept || timeout) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_d = '0;
        done_d  = '0;
        err_d   = '0;
        mdr_d   = 1'b0;
        busy_d  = (state_nx != S_IDLE);
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    grant_d[winner] = 1'b1;
                    mdr_d           = 1'b1;
                end
            end
            S_WAIT: begin
                if (accept)       done_d[owner] = 1'b1;
                else if (timeout) err_d[owner]  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            rr_last          <= IW'(NREQ - 1);
            owner            <= '0;
            cnt              <= '0;
            rdy_q            <= 1'b0;
            bus.grant        <= '0;
            bus.done         <= '0;
            bus.err          <= '0;
            bus.res          <= '0;
            bus.busy         <= 1'b0;
            bus.m_a          <= '0;
            bus.m_b          <= '0;
            bus.m_data_ready <= 1'b0;
        end else begin
            state            <= state_nx;
            rdy_q            <= bus.m_result_ready;
            bus.grant        <= grant_d;
            bus.done         <= done_d;
            bus.err          <= err_d;
            bus.busy         <= busy_d;
            bus.m_data_ready <= mdr_d;
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        owner   <= winner;
                        bus.m_a <= bus.op_a[int'(winner)*N +: N];
                        bus.m_b <= bus.op_b[int'(winner)*N +: N];
                    end
                end
                S_START: cnt <= '0;
                S_WAIT: begin
                    if (accept)        bus.res <= bus.m_result;
                    else if (!timeout) cnt     <= cnt + CW'(1);
                end
                S_DONE: begin
                    rr_last <= owner;
                    cnt     <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - directed self-checking bench for mult_rr_scheduler
module tb_mult_rr_scheduler;
    logic clk;
    logic reset;

    mult_rr_scheduler_if #(.N(4), .NREQ(4)) bus();

    mult_rr_scheduler #(.N(4), .NREQ(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors       = 0;
    int checks       = 0;
    int extra_grants = 0;
    int extra_mdr    = 0;
    int mode         = 0;   // 0 pulse after lat cycles, 1 never answers, 2 stuck high
    int lat          = 3;
    int mcnt         = 0;

    // Multiplier stand-in; updates 2 time units after each rising edge.
    initial begin
        bus.m_result_ready = 1'b0;
        bus.m_result       = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 2) begin
                bus.m_result_ready = 1'b1;
            end else begin
                bus.m_result_ready = 1'b0;
                if (bus.m_data_ready) begin
                    mcnt = lat;
                end else if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0 && mode == 0) begin
                        bus.m_result_ready = 1'b1;
                        bus.m_result       = {4'd0, bus.m_a} * {4'd0, bus.m_b};
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx, output int n);
        idx = -1;
        n   = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.grant != 0) begin
                n = i;
                break;
            end
        end
        if (n == 0) check_eq("grant_timeout", 0, 1);
        for (int j = 0; j < 4; j++) if (bus.grant[j]) idx = j;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.grant != 0) extra_grants++;
            if (bus.m_data_ready) extra_mdr++;
            if ((bus.done | bus.err) != 0) begin
                n = i;
                break;
            end
        end
        if (n == 0) check_eq("end_timeout", 0, 1);
    endtask

    // One full operation: grant one cycle after IDLE, end etime cycles after grant.
    task automatic serve(input string tag, input int eidx, input int etime, input bit eerr,
                         input logic [7:0] eres, input bit drop);
        int idx;
        int n;
        wait_grant(idx, n);
        check_eq({tag, "_idx"}, idx, eidx);
        check_eq({tag, "_glat"}, n, 1);
        check_eq({tag, "_mdr"}, bus.m_data_ready, 1);
        check_eq({tag, "_busy"}, bus.busy, 1);
        wait_end(n);
        check_eq({tag, "_elat"}, n, etime);
        check_eq({tag, "_done"}, bus.done, eerr ? 4'b0 : 4'(1 << eidx));
        check_eq({tag, "_err"}, bus.err, eerr ? 4'(1 << eidx) : 4'b0);
        check_eq({tag, "_res"}, bus.res, eres);
        if (drop) bus.req = 4'b0;
        step();
        check_eq({tag, "_idle_busy"}, bus.busy, 0);
        check_eq({tag, "_idle_pulse"}, {bus.grant, bus.done, bus.err}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    initial begin
        int idx;
        int n;
        reset    = 1'b0;
        bus.req  = 4'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) step();
        check_eq("rst_grant", bus.grant, 0);
        check_eq("rst_done_err", {bus.done, bus.err}, 0);
        check_eq("rst_res", bus.res, 0);
        check_eq("rst_busy_mdr", {bus.busy, bus.m_data_ready}, 0);
        check_eq("rst_mab", {bus.m_a, bus.m_b}, 0);

        // 15 x 15 on requester 0 with a 6-cycle multiplier
        reset    = 1'b1;
        step();
        lat      = 6;
        bus.op_a = 16'h000F;
        bus.op_b = 16'h000F;
        bus.req  = 4'b0001;
        serve("t1", 0, 7, 1'b0, 8'd225, 1'b1);
        check_eq("t1_mab_held", {bus.m_a, bus.m_b}, 8'hFF);

        // All four requesting: products 3, 10, 21, 36
        do_reset();
        lat      = 3;
        bus.op_a = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.op_b = {4'd9, 4'd7, 4'd5, 4'd3};
        bus.req  = 4'b1111;
        serve("t2a", 0, 4, 1'b0, 8'd3, 1'b0);
        serve("t2b", 1, 4, 1'b0, 8'd10, 1'b0);
        serve("t2c", 2, 4, 1'b0, 8'd21, 1'b0);
        serve("t2d", 3, 4, 1'b0, 8'd36, 1'b0);
        serve("t2e", 0, 4, 1'b0, 8'd3, 1'b1);

        // Sparse requests 0 and 2 alternate
        do_reset();
        bus.req = 4'b0101;
        serve("t3a", 0, 4, 1'b0, 8'd3, 1'b0);
        serve("t3b", 2, 4, 1'b0, 8'd21, 1'b0);
        serve("t3c", 0, 4, 1'b0, 8'd3, 1'b0);
        serve("t3d", 2, 4, 1'b0, 8'd21, 1'b1);

        // Silent multiplier: timeout on 3, then pending 1 served normally
        mode    = 1;
        bus.req = 4'b1010;
        serve("t4a", 3, 65, 1'b1, 8'd21, 1'b0);
        mode    = 0;
        serve("t4b", 1, 4, 1'b0, 8'd10, 1'b1);

        // Result-ready stuck high from before START, then a clean edge
        mode = 2;
        step();
        step();
        bus.req = 4'b0001;
        serve("t5a", 0, 65, 1'b1, 8'd10, 1'b1);
        mode = 0;
        step();
        step();
        bus.req = 4'b0001;
        serve("t5b", 0, 4, 1'b0, 8'd3, 1'b1);

        // Reset asserted mid-WAIT
        mode    = 1;
        bus.req = 4'b0100;
        wait_grant(idx, n);
        check_eq("t6_idx", idx, 2);
        bus.req = 4'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check_eq("t6_grant", bus.grant, 0);
        check_eq("t6_done_err", {bus.done, bus.err}, 0);
        check_eq("t6_mdr_busy", {bus.m_data_ready, bus.busy}, 0);
        check_eq("t6_res", bus.res, 0);
        step();
        step();
        check_eq("t6_quiet", {bus.done, bus.err, bus.busy}, 0);
        reset   = 1'b1;
        mode    = 0;
        bus.req = 4'b1010;
        serve("t6b", 1, 4, 1'b0, 8'd10, 1'b1);

        check_eq("single_in_flight", extra_grants, 0);
        check_eq("mdr_one_pulse", extra_mdr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
